// File: rtl/voice_alloc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : voice_alloc_pkg
//  Description : Shared defaults, FSM state type and rank-width helper for
//                the polyphonic voice allocator.
//  Revision    : 1.0 - initial release
// ============================================================================
package voice_alloc_pkg;

    localparam int VOICES_DEF = 4;
    localparam int NOTE_W_DEF = 7;

    // Width of an age rank (and of a voice index) for a given voice count.
    function automatic int rank_width(input int voices);
        return (voices < 2) ? 1 : $clog2(voices);
    endfunction

    localparam int RANK_W_DEF = rank_width(VOICES_DEF);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/voice_age_rank.sv
`default_nettype none
// ============================================================================
//  Module      : voice_age_rank
//  Description : Per-voice age ranks (0 = newest, VOICES-1 = oldest). A commit
//                moves the target to rank 0 and ages every younger voice by
//                one, so the ranks always stay a permutation.
//  Revision    : 1.0 - initial release
// ============================================================================
module voice_age_rank
    import voice_alloc_pkg::*;
#(
    parameter int VOICES = VOICES_DEF,
    parameter int RANK_W = rank_width(VOICES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     commit_i,
    input  logic [RANK_W-1:0]        target_i,
    output logic [VOICES*RANK_W-1:0] rank_o,
    output logic [RANK_W-1:0]        oldest_o
);

    logic [VOICES*RANK_W-1:0] rank_q;
    logic [RANK_W-1:0]        old_rank_w;
    logic [RANK_W-1:0]        oldest_w;

    assign old_rank_w = rank_q[target_i*RANK_W +: RANK_W];

    // Reset to identity ranks; on commit the target becomes newest and
    // every voice younger than its old rank ages by one.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < VOICES; i++) begin
                rank_q[i*RANK_W +: RANK_W] <= RANK_W'(i);
            end
        end else if (commit_i) begin
            for (int i = 0; i < VOICES; i++) begin
                if (target_i == RANK_W'(i)) begin
                    rank_q[i*RANK_W +: RANK_W] <= '0;
                end else if (rank_q[i*RANK_W +: RANK_W] < old_rank_w) begin
                    rank_q[i*RANK_W +: RANK_W] <= rank_q[i*RANK_W +: RANK_W] + 1'b1;
                end
            end
        end
    end

    // Exactly one voice holds the maximum rank; report its index.
    always_comb begin
        oldest_w = '0;
        for (int i = 0; i < VOICES; i++) begin
            if (rank_q[i*RANK_W +: RANK_W] == RANK_W'(VOICES-1)) begin
                oldest_w = RANK_W'(i);
            end
        end
    end

    assign rank_o   = rank_q;
    assign oldest_o = oldest_w;

endmodule
`default_nettype wire

// File: rtl/voice_alloc.sv
`default_nettype none
// ============================================================================
//  Module      : voice_alloc
//  Description : Polyphonic voice allocator. Each key event is scanned one
//                voice per cycle (match / free search), then committed:
//                note-on retriggers, takes a free voice, or steals the
//                oldest; note-off releases matching gated voices.
//  Revision    : 1.0 - initial release
// ============================================================================
module voice_alloc
    import voice_alloc_pkg::*;
#(
    parameter int VOICES = VOICES_DEF,
    parameter int NOTE_W = NOTE_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ev_valid,
    input  logic                     ev_on,
    input  logic [NOTE_W-1:0]        ev_note,
    output logic                     ev_ready,
    input  logic                     panic,
    output logic [VOICES*NOTE_W-1:0] voice_note,
    output logic [VOICES-1:0]        voice_gate,
    output logic [VOICES-1:0]        voice_trig
);

    localparam int RANK_W = rank_width(VOICES);

    state_t                   state_q;
    logic [RANK_W-1:0]        scan_idx_q;
    logic                     ev_on_q;
    logic [NOTE_W-1:0]        ev_note_q;
    logic                     match_found_q;
    logic [RANK_W-1:0]        match_idx_q;
    logic                     free_found_q;
    logic [RANK_W-1:0]        free_idx_q;
    logic [VOICES-1:0]        off_mask_q;
    logic [VOICES*NOTE_W-1:0] note_q;
    logic [VOICES-1:0]        gate_q;
    logic [VOICES-1:0]        trig_q;

    logic                     rank_commit_w;
    logic [RANK_W-1:0]        target_w;
    logic [RANK_W-1:0]        oldest_w;
    logic [VOICES*RANK_W-1:0] rank_w;
    logic [NOTE_W-1:0]        scan_note_w;
    logic                     scan_gate_w;
    logic                     scan_hit_w;

    // Ranks are exported by the age tracker for observability; the allocator
    // itself only needs the oldest index.
    logic unused_rank_w;
    assign unused_rank_w = ^rank_w;

    assign ev_ready = (state_q == ST_IDLE) & ~panic & ~rst;

    // Only a note-on commit reorders the ages.
    assign rank_commit_w = (state_q == ST_COMMIT) & ev_on_q & ~panic & ~rst;

    assign scan_note_w = note_q[scan_idx_q*NOTE_W +: NOTE_W];
    assign scan_gate_w = gate_q[scan_idx_q];
    assign scan_hit_w  = scan_gate_w & (scan_note_w == ev_note_q);

    // Target priority from registered scan results: retrigger, free, steal.
    always_comb begin
        target_w = oldest_w;
        if (match_found_q) begin
            target_w = match_idx_q;
        end else if (free_found_q) begin
            target_w = free_idx_q;
        end
    end

    voice_age_rank #(
        .VOICES (VOICES),
        .RANK_W (RANK_W)
    ) u_rank (
        .clk      (clk),
        .rst      (rst),
        .commit_i (rank_commit_w),
        .target_i (target_w),
        .rank_o   (rank_w),
        .oldest_o (oldest_w)
    );

    // Event FSM: latch on accept, scan one voice per cycle, commit, return idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            scan_idx_q    <= '0;
            ev_on_q       <= 1'b0;
            ev_note_q     <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            off_mask_q    <= '0;
            note_q        <= '0;
            gate_q        <= '0;
            trig_q        <= '0;
        end else if (panic) begin
            state_q <= ST_IDLE;
            gate_q  <= '0;
            trig_q  <= '0;
        end else begin
            trig_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (ev_valid) begin
                        ev_on_q       <= ev_on;
                        ev_note_q     <= ev_note;
                        scan_idx_q    <= '0;
                        match_found_q <= 1'b0;
                        free_found_q  <= 1'b0;
                        off_mask_q    <= '0;
                        state_q       <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (scan_hit_w) begin
                        off_mask_q[scan_idx_q] <= 1'b1;
                        if (!match_found_q) begin
                            match_found_q <= 1'b1;
                            match_idx_q   <= scan_idx_q;
                        end
                    end
                    if (!scan_gate_w && !free_found_q) begin
                        free_found_q <= 1'b1;
                        free_idx_q   <= scan_idx_q;
                    end
                    if (scan_idx_q == RANK_W'(VOICES-1)) begin
                        state_q <= ST_COMMIT;
                    end else begin
                        scan_idx_q <= scan_idx_q + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    if (ev_on_q) begin
                        note_q[target_w*NOTE_W +: NOTE_W] <= ev_note_q;
                        gate_q[target_w]                  <= 1'b1;
                        trig_q[target_w]                  <= 1'b1;
                    end else begin
                        gate_q <= gate_q & ~off_mask_q;
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign voice_note = note_q;
    assign voice_gate = gate_q;
    assign voice_trig = trig_q;

endmodule
`default_nettype wire

// File: doc/voice_alloc.md
VOICE_ALLOC -- requirements
Module: voice_alloc

Interface
REQ-001 Parameter VOICES, default 4, number of voices managed (power of two, 2..8).
REQ-002 Parameter NOTE_W, default 7, note number width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ev_valid  input  1  key event present.
REQ-006 ev_on  input  1  1 = note-on, 0 = note-off; qualified by ev_valid.
REQ-007 ev_note  input  NOTE_W  key number of the event.
REQ-008 ev_ready  output  1  block can accept an event this cycle.
REQ-009 panic  input  1  all-notes-off request.
REQ-010 voice_note  output  VOICES*NOTE_W  note per voice; voice i in slice [i*NOTE_W +: NOTE_W].
REQ-011 voice_gate  output  VOICES  gate per voice.
REQ-012 voice_trig  output  VOICES  one-cycle retrigger pulse per voice.

Function
REQ-013 Event accepted on an edge where ev_valid & ev_ready; ev_on/ev_note are latched at that edge; inputs are ignored when ev_ready=0.
REQ-014 FSM states are IDLE, SCAN and COMMIT; ev_ready=1 only in IDLE.
REQ-015 Transitions: IDLE->SCAN on accept; SCAN lasts exactly VOICES cycles, examining voice k in SCAN cycle k; SCAN->COMMIT; COMMIT->IDLE.
REQ-016 Outputs change at the (VOICES+1)th edge after the accept edge; ev_ready is high again in the cycle after that edge.
REQ-017 Note-on target priority: (a) the lowest-index voice with gate=1 and the same note (retrigger); else (b) the lowest-index voice with gate=0; else (c) the voice with age rank VOICES-1 (oldest; steal).
REQ-018 On note-on commit: the target gets voice_note=ev_note and gate=1, voice_trig[target]=1 for the following cycle only, and the target's rank becomes 0.
REQ-019 Age ranks are always a permutation of 0..VOICES-1; on commit, every voice whose rank is below the target's old rank increments its rank by 1, and all other ranks are unchanged.
REQ-020 On note-off commit: every voice with gate=1 and a matching note has gate cleared; voice_note, ranks and trig are unchanged.
REQ-021 A note-off with no matching gated voice has no effect on any output.
REQ-022 A stolen voice keeps gate=1 across the steal; only its note and trig change.
REQ-023 panic=1: at the next edge all gates and trigs are cleared, any in-flight event is discarded, the FSM goes to IDLE, and notes/ranks are retained; ev_ready=0 while panic=1.
REQ-024 rst has priority over panic, and panic has priority over accept and commit.
REQ-025 At most one voice_trig bit is high in any cycle.

Reset
REQ-026 rst clears voice_gate, voice_trig and voice_note to 0, sets the FSM to IDLE, sets the rank of voice i to i, and discards any latched event.
REQ-027 ev_ready is 0 during the rst cycle and 1 in the first cycle after rst deasserts.
REQ-028 A reset mid-SCAN or in COMMIT aborts the event with no output change other than the reset values.

Structure
REQ-029 A shared package holds VOICES/NOTE_W defaults, the FSM state type (IDLE/SCAN/COMMIT), and the rank width constant clog2(VOICES).
REQ-030 A single sub-module voice_age_rank holds the per-voice ranks, with inputs for the commit strobe and target index and outputs for the ranks and the oldest index.
REQ-031 Scan results (match index, free index, found flags) are registered and the scan is sequential; there is no combinational all-voice search into the outputs.

Verification
REQ-032 After reset, note-on 60, 62, 64, 67 are applied back-to-back -> voices 0..3 hold 60/62/64/67, all gates=1, each trig pulses once, and the inter-accept spacing is VOICES+2 cycles.
REQ-033 From that state, note-on 72 -> voice 0 is stolen: note=72, gate stays 1, trig[0] pulses, and voice 1 becomes oldest.
REQ-034 Note-off 62, then note-on 50 -> gate[1]=0 after the first event; after the second, voice 1 has note 50 and gate=1 (free voice preferred over stealing).
REQ-035 Note-on 64 while 64 is gated on voice 2 -> voice 2 retriggers, no other voice changes, and rank[2]=0.
REQ-036 Note-off 99 with no match -> all outputs are unchanged; panic mid-SCAN -> all gates=0 next cycle and the event is lost.
REQ-037 rst asserted in COMMIT -> all outputs are at reset values and ranks are 0,1,2,3.
